arbitro_ram16k: RTL
===================

Name: arbitro_ram16k

Overview:
Two-requester round-robin arbiter and access sequencer for the 16K x 16 RAM (minha_ram16k).
- Shares one RAM port between requester 0 (CPU side) and requester 1 (loader/DMA side) using a req/ack handshake.
- Registers the winning address, data and write-enable, sequences a single RAM access, and returns read data to the winner.
- Sits between the requesters and the RAM instance at the memory-subsystem level.

Parameters:
LARGURA_DADOS, 16, data width; fixed by the RAM
LARGURA_END, 14, address width; fixed by the RAM (16K words)

Ports:
clock_sistema  input  1  system clock; all state changes on rising edge
reset_sistema  input  1  asynchronous, active-high reset
req0  input  1  requester 0 access request; held high until ack0
we0  input  1  requester 0: 1 = write, 0 = read; stable while req0 is high
end0  input  14  requester 0 word address
dado0  input  16  requester 0 write data
ack0  output  1  one-cycle pulse: requester 0 access complete
saida0  output  16  requester 0 read data; valid from the ack0 cycle until its next read ack
req1, we1, end1, dado1, ack1, saida1  same as above, for requester 1
ram_entrada  output  16  to RAM entrada_dados
ram_endereco  output  14  to RAM endereco_mem
ram_escrita  output  1  to RAM controle_escrita
ram_saida  input  16  from RAM saida_dados; combinational read of ram_endereco
ocupado  output  1  high whenever state != OCIOSO

Behaviour:
- Reset (asynchronous, takes effect immediately) sets:
  - state = OCIOSO; ultimo (last-granted pointer) = 1, so requester 0 wins the first tie.
  - ack0 = ack1 = 0; ram_escrita = 0; ram_endereco = 0; ram_entrada = 0.
  - saida0 = saida1 = 0; ocupado = 0.
- Reset mid-access: state drops to OCIOSO and ram_escrita goes low before the next edge, so no write commits. The pending request gets no ack; the requester re-arbitrates after reset.
- State machine (OCIOSO -> ACESSO -> RESPOSTA -> OCIOSO):
  - OCIOSO:
    - No req: stay.
    - Only one req: grant it.
    - Both req: grant the requester != ultimo.
    - On grant, latch that requester's end, dado, we into ram_endereco, ram_entrada and a we register; record vencedor; go to ACESSO.
  - ACESSO (exactly 1 cycle):
    - ram_escrita = we register, combinationally gated with state==ACESSO.
    - Write: the RAM commits at the ACESSO->RESPOSTA edge.
    - Read: ram_saida is captured into saida of the vencedor at that same edge. The other requester's saida is untouched.
    - ultimo <= vencedor. Go to RESPOSTA.
  - RESPOSTA (1 cycle):
    - ack of the vencedor = 1, registered, all other cycles 0.
    - Both reqs are ignored this cycle, even if the vencedor still holds req.
    - Go to OCIOSO.
- Latency: req high at edge k in OCIOSO -> ram_escrita/ram_endereco valid in cycle k+1 -> ack in cycle k+2. Worst case a losing requester waits 3 extra cycles. Peak throughput is 1 access per 3 cycles.
- Requester rules:
  - req, we, end, dado must be held stable until the ack cycle.
  - req may stay high in the ack cycle; this is treated as a new request at the next OCIOSO.
  - Changing inputs before ack is a protocol violation; the arbiter uses the values latched at grant.
- Writes do not modify saida. Read-after-write to the same address by either requester returns the new data.
- ram_escrita is never high outside ACESSO.
- Exactly one of ack0/ack1 may be high in any cycle.
- Address width is fixed at 14 bits with no wrap logic; 0x3FFF is a legal address.

Decomposition:
- Shared package: state encoding constants (OCIOSO=2'd0, ACESSO=2'd1, RESPOSTA=2'd2), LARGURA_DADOS, LARGURA_END.
- One sub-module is natural: arbitro_rr2, the combinational 2-way round-robin winner pick (inputs req0, req1, ultimo; outputs vencedor, valido).
- The RAM is not instantiated inside; integration instantiates arbitro_ram16k plus minha_ram16k.

Test Plan:
- Reset then idle -> all outputs 0, ocupado 0 for 10 cycles; assert reset during ACESSO with we0=1 -> no write; a later read of that address returns the old value.
- req0 write end0=0x0005 dado0=0xBEEF, then req0 read 0x0005 -> write: ack0 exactly 2 cycles after req0 sampled; read: saida0=0xBEEF at ack0; saida1 unchanged.
- req0 and req1 both raised in the same cycle after reset, reads -> requester 0 acked first, requester 1 acked 3 cycles later; no overlapping acks.
- Both requesters hold req continuously for 12 accesses -> grants strictly alternate 0,1,0,1...; 6 acks each.
- Boundary addresses: req1 writes 0x3FFF=0x1234 and 0x0000=0xFFFF, req0 reads both -> 0x1234 and 0xFFFF; ram_escrita high only in ACESSO cycles.
- req1 keeps req high through ack1 with unchanged inputs and req0 is low -> second access is granted to req1 at the next OCIOSO; no double write within a single ACESSO.

Source files
------------

// File: rtl/arbitro_ram16k_pkg.sv
// Shared constants and state encoding for the 16K x 16 RAM arbiter.
package arbitro_ram16k_pkg;
   localparam int LARGURA_DADOS = 16;
   localparam int LARGURA_END   = 14;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      ACESSO   = 2'd1,
      RESPOSTA = 2'd2
   } estado_t;
endpackage

// File: rtl/arbitro_ram16k_rr2.sv
// Combinational 2-way round-robin pick: on a tie the requester that did not win last time wins.
module arbitro_ram16k_rr2 (
   input  logic req0,
   input  logic req1,
   input  logic ultimo,
   output logic vencedor,
   output logic valido
);
   always_comb begin
      valido   = req0 | req1;
      vencedor = (req0 & req1) ? ~ultimo : req1;
   end
endmodule

// File: rtl/arbitro_ram16k.sv
// Shares one single-port 16K x 16 RAM between two req/ack requesters; one access per 3 cycles,
// ack two cycles after grant. A losing requester simply holds req until its ack arrives.
module arbitro_ram16k
   import arbitro_ram16k_pkg::*;
(
   input  logic                     clock_sistema,
   input  logic                     reset_sistema,
   input  logic                     req0,
   input  logic                     we0,
   input  logic [LARGURA_END-1:0]   end0,
   input  logic [LARGURA_DADOS-1:0] dado0,
   output logic                     ack0,
   output logic [LARGURA_DADOS-1:0] saida0,
   input  logic                     req1,
   input  logic                     we1,
   input  logic [LARGURA_END-1:0]   end1,
   input  logic [LARGURA_DADOS-1:0] dado1,
   output logic                     ack1,
   output logic [LARGURA_DADOS-1:0] saida1,
   output logic [LARGURA_DADOS-1:0] ram_entrada,
   output logic [LARGURA_END-1:0]   ram_endereco,
   output logic                     ram_escrita,
   input  logic [LARGURA_DADOS-1:0] ram_saida,
   output logic                     ocupado
);
   estado_t estado, estado_prox;
   logic    ultimo;
   logic    vencedor_r;
   logic    we_r;
   logic    vencedor;
   logic    valido;

   arbitro_ram16k_rr2 u_rr2 (
      .req0     (req0),
      .req1     (req1),
      .ultimo   (ultimo),
      .vencedor (vencedor),
      .valido   (valido)
   );

   always_ff @(posedge clock_sistema or posedge reset_sistema) begin
      if (reset_sistema) estado <= OCIOSO;
      else               estado <= estado_prox;
   end

   always_comb begin
      estado_prox = estado;
      case (estado)
         OCIOSO:   if (valido) estado_prox = ACESSO;
         ACESSO:   estado_prox = RESPOSTA;
         RESPOSTA: estado_prox = OCIOSO;
         default:  estado_prox = OCIOSO;
      endcase
   end

   always_ff @(posedge clock_sistema or posedge reset_sistema) begin
      if (reset_sistema) begin
         ultimo       <= 1'b1;
         vencedor_r   <= 1'b0;
         we_r         <= 1'b0;
         ram_endereco <= '0;
         ram_entrada  <= '0;
         ack0         <= 1'b0;
         ack1         <= 1'b0;
         saida0       <= '0;
         saida1       <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (valido) begin
                  vencedor_r   <= vencedor;
                  ram_endereco <= vencedor ? end1  : end0;
                  ram_entrada  <= vencedor ? dado1 : dado0;
                  we_r         <= vencedor ? we1   : we0;
               end
            end
            ACESSO: begin
               // Read data is taken on the same edge the RAM would commit a write.
               ultimo <= vencedor_r;
               if (vencedor_r) ack1 <= 1'b1;
               else            ack0 <= 1'b1;
               if (!we_r) begin
                  if (vencedor_r) saida1 <= ram_saida;
                  else            saida0 <= ram_saida;
               end
            end
            default: ;
         endcase
      end
   end

   // Gating with the state keeps a reset mid-access from committing the write.
   assign ram_escrita = we_r & (estado == ACESSO);
   assign ocupado     = (estado != OCIOSO);
endmodule
